// File: rtl/router_pkg.sv
// Shared types and constants for the router packet-sequencing controller.
// The state encoding is fixed at 3 bits with DECODE_ADDRESS as the reset
// value so the debug state output reads 0 straight out of reset.
package router_pkg;

   typedef enum logic [2:0] {
      DECODE_ADDRESS     = 3'd0,
      LOAD_FIRST_DATA    = 3'd1,
      LOAD_DATA          = 3'd2,
      FIFO_FULL_STATE    = 3'd3,
      LOAD_AFTER_FULL    = 3'd4,
      LOAD_PARITY        = 3'd5,
      CHECK_PARITY_ERROR = 3'd6,
      WAIT_TILL_EMPTY    = 3'd7
   } state_e;

   localparam logic [1:0] ADDR_INVALID = 2'b11;
   localparam int         NUM_DEST     = 3;

   // Select one per-destination flag by a 2-bit address; the invalid
   // address reads as 0 so it can never look like an empty or reset FIFO.
   function automatic logic pick_dest(input logic [NUM_DEST-1:0] flags,
                                      input logic [1:0]          addr);
      logic sel;
      sel = 1'b0;
      case (addr)
         2'd0:    sel = flags[0];
         2'd1:    sel = flags[1];
         2'd2:    sel = flags[2];
         default: sel = 1'b0;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/router_pkt_ctrl_nsl.sv
// Next-state logic of the packet-sequencing controller, kept combinational
// and free of registers so the state table reads in one place.
// Optional feature macro: ROUTER_PKT_CTRL_WAIT_TIMEOUT_EN adds the
// wait-expired input and the drop indication.
module router_pkt_ctrl_nsl
   import router_pkg::*;
(
   input  state_e              state_i,
   input  logic [1:0]          addr_q_i,
   input  logic                pkt_valid_i,
   input  logic [1:0]          data_in_i,
   input  logic                fifo_full_i,
   input  logic [NUM_DEST-1:0] fifo_empty_i,
   input  logic [NUM_DEST-1:0] soft_reset_i,
   input  logic                parity_done_i,
   input  logic                low_pkt_valid_i,
`ifdef ROUTER_PKT_CTRL_WAIT_TIMEOUT_EN
   input  logic                wait_expired_i,
   output logic                drop_o,
`endif
   output state_e              state_d_o
);

   logic hdr_empty;   // empty flag of the FIFO addressed by the incoming header
   logic sel_empty;   // empty flag of the latched destination
   logic sel_soft;    // soft reset of the latched destination

   assign hdr_empty = pick_dest(fifo_empty_i, data_in_i);
   assign sel_empty = pick_dest(fifo_empty_i, addr_q_i);
   assign sel_soft  = pick_dest(soft_reset_i, addr_q_i);

   // State table; a soft reset of the latched destination aborts any packet.
   always_comb begin
      state_d_o = state_i;
`ifdef ROUTER_PKT_CTRL_WAIT_TIMEOUT_EN
      drop_o    = 1'b0;
`endif
      if (state_i != DECODE_ADDRESS && sel_soft) begin
         state_d_o = DECODE_ADDRESS;
      end else begin
         case (state_i)
            DECODE_ADDRESS: begin
               if (pkt_valid_i && data_in_i != ADDR_INVALID)
                  state_d_o = hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            end
            LOAD_FIRST_DATA: state_d_o = LOAD_DATA;
            LOAD_DATA: begin
               if (fifo_full_i)       state_d_o = FIFO_FULL_STATE;
               else if (!pkt_valid_i) state_d_o = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
               if (!fifo_full_i) state_d_o = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
               if (parity_done_i)        state_d_o = DECODE_ADDRESS;
               else if (low_pkt_valid_i) state_d_o = LOAD_PARITY;
               else                      state_d_o = LOAD_DATA;
            end
            LOAD_PARITY: state_d_o = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
               state_d_o = fifo_full_i ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            WAIT_TILL_EMPTY: begin
               if (sel_empty) begin
                  state_d_o = LOAD_FIRST_DATA;
               end
`ifdef ROUTER_PKT_CTRL_WAIT_TIMEOUT_EN
               else if (wait_expired_i) begin
                  state_d_o = DECODE_ADDRESS;
                  drop_o    = 1'b1;
               end
`endif
            end
            default: state_d_o = DECODE_ADDRESS;
         endcase
      end
   end

endmodule

// File: rtl/router_pkt_ctrl.sv
// Packet-sequencing controller for the 1-to-3 router: decodes the header
// address, sequences header/payload/parity loads and handles stalls.
// Optional feature macro: ROUTER_PKT_CTRL_WAIT_TIMEOUT_EN (bounded wait for
// a busy destination, with a one-cycle pkt_dropped pulse on expiry).
//
// Handshake: the input port presents a byte whenever pkt_valid is high and
// must hold that byte (not advance) in every cycle where busy is high; a
// byte is consumed in any cycle with pkt_valid high and busy low.
module router_pkt_ctrl
   import router_pkg::*;
#(
   parameter int WAIT_LIMIT = 64,
   parameter int WCNT_W     = 7
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       pkt_valid,
   input  logic [1:0] data_in,
   input  logic       fifo_full,
   input  logic       fifo_empty_0,
   input  logic       fifo_empty_1,
   input  logic       fifo_empty_2,
   input  logic       soft_reset_0,
   input  logic       soft_reset_1,
   input  logic       soft_reset_2,
   input  logic       parity_done,
   input  logic       low_pkt_valid,
   output logic       detect_add,
   output logic       lfd_state,
   output logic       ld_state,
   output logic       laf_state,
   output logic       full_state,
   output logic       write_enb_reg,
   output logic       rst_int_reg,
   output logic       busy,
`ifdef ROUTER_PKT_CTRL_WAIT_TIMEOUT_EN
   output logic       pkt_dropped,
`endif
   output logic [2:0] state_dbg
);

   // The wait counter must be able to reach WAIT_LIMIT-1.
   if (WCNT_W < 1 || WAIT_LIMIT < 1 || WAIT_LIMIT > (1 << WCNT_W)) begin : g_bad_cfg
      $error("router_pkt_ctrl: WCNT_W is too narrow for WAIT_LIMIT");
   end

   state_e     state_q, state_d;
   logic [1:0] addr_q, addr_d;

`ifdef ROUTER_PKT_CTRL_WAIT_TIMEOUT_EN
   logic [WCNT_W-1:0] wcnt_q, wcnt_d;
   logic              wait_expired;
   logic              drop;
   logic              dropped_q;

   assign wait_expired = (wcnt_q == WCNT_W'(WAIT_LIMIT - 1));

   // Wait counter runs only while parked in WAIT_TILL_EMPTY, zero elsewhere,
   // so every entry into the wait starts from 0.
   always_comb begin
      wcnt_d = '0;
      if (state_q == WAIT_TILL_EMPTY)
         wcnt_d = wcnt_q + {{(WCNT_W-1){1'b0}}, 1'b1};
   end

   // Wait counter and registered drop pulse.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wcnt_q    <= '0;
         dropped_q <= 1'b0;
      end else begin
         wcnt_q    <= wcnt_d;
         dropped_q <= drop;
      end
   end

   assign pkt_dropped = dropped_q;
`endif

   router_pkt_ctrl_nsl u_nsl (
      .state_i         (state_q),
      .addr_q_i        (addr_q),
      .pkt_valid_i     (pkt_valid),
      .data_in_i       (data_in),
      .fifo_full_i     (fifo_full),
      .fifo_empty_i    ({fifo_empty_2, fifo_empty_1, fifo_empty_0}),
      .soft_reset_i    ({soft_reset_2, soft_reset_1, soft_reset_0}),
      .parity_done_i   (parity_done),
      .low_pkt_valid_i (low_pkt_valid),
`ifdef ROUTER_PKT_CTRL_WAIT_TIMEOUT_EN
      .wait_expired_i  (wait_expired),
      .drop_o          (drop),
`endif
      .state_d_o       (state_d)
   );

   // Latch the destination when a valid header leaves DECODE_ADDRESS.
   always_comb begin
      addr_d = addr_q;
      if (state_q == DECODE_ADDRESS && state_d != DECODE_ADDRESS)
         addr_d = data_in;
   end

   // State and destination registers.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= DECODE_ADDRESS;
         addr_q  <= 2'd0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
      end
   end

   // Moore output decode from the current state only.
   always_comb begin
      detect_add    = 1'b0;
      lfd_state     = 1'b0;
      ld_state      = 1'b0;
      laf_state     = 1'b0;
      full_state    = 1'b0;
      write_enb_reg = 1'b0;
      rst_int_reg   = 1'b0;
      busy          = 1'b0;
      case (state_q)
         DECODE_ADDRESS:  detect_add = 1'b1;
         LOAD_FIRST_DATA: begin
            lfd_state = 1'b1;
            busy      = 1'b1;
         end
         LOAD_DATA: begin
            ld_state      = 1'b1;
            write_enb_reg = 1'b1;
         end
         FIFO_FULL_STATE: begin
            full_state = 1'b1;
            busy       = 1'b1;
         end
         LOAD_AFTER_FULL: begin
            laf_state     = 1'b1;
            busy          = 1'b1;
            write_enb_reg = 1'b1;
         end
         LOAD_PARITY: begin
            busy          = 1'b1;
            write_enb_reg = 1'b1;
         end
         CHECK_PARITY_ERROR: begin
            rst_int_reg = 1'b1;
            busy        = 1'b1;
         end
         WAIT_TILL_EMPTY: busy = 1'b1;
         default: ;
      endcase
   end

   assign state_dbg = state_q;

endmodule

// File: tb/tb_router_pkt_ctrl.sv
// Self-checking bench for router_pkt_ctrl: directed scenarios followed by a
// randomized run against a rule-level reference model.
module tb_router_pkt_ctrl;

`ifdef ROUTER_PKT_CTRL_WAIT_TIMEOUT_EN
   localparam int WL         = 8;
   localparam bit TIMEOUT_EN = 1'b1;
`else
   localparam int WL         = 64;
   localparam bit TIMEOUT_EN = 1'b0;
`endif

   // Output vector order: {detect_add, lfd, ld, laf, full, wen, rst_int, busy}
   localparam logic [7:0] V_DA   = 8'b1000_0000;
   localparam logic [7:0] V_LFD  = 8'b0100_0001;
   localparam logic [7:0] V_LD   = 8'b0010_0100;
   localparam logic [7:0] V_LAF  = 8'b0001_0101;
   localparam logic [7:0] V_FULL = 8'b0000_1001;
   localparam logic [7:0] V_LP   = 8'b0000_0101;
   localparam logic [7:0] V_CPE  = 8'b0000_0011;
   localparam logic [7:0] V_WAIT = 8'b0000_0001;

   logic       clock = 1'b0;
   logic       resetn;
   logic       pkt_valid;
   logic [1:0] data_in;
   logic       fifo_full;
   logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
   logic       soft_reset_0, soft_reset_1, soft_reset_2;
   logic       parity_done;
   logic       low_pkt_valid;
   logic       detect_add, lfd_state, ld_state, laf_state, full_state;
   logic       write_enb_reg, rst_int_reg, busy;
   logic [2:0] state_dbg;
`ifdef ROUTER_PKT_CTRL_WAIT_TIMEOUT_EN
   logic       pkt_dropped;
`endif
   logic [7:0] dut_vec;

   int checks   = 0;
   int failures = 0;

   assign dut_vec = {detect_add, lfd_state, ld_state, laf_state, full_state,
                     write_enb_reg, rst_int_reg, busy};

   router_pkt_ctrl #(.WAIT_LIMIT(WL), .WCNT_W(7)) dut (
      .clock         (clock),
      .resetn        (resetn),
      .pkt_valid     (pkt_valid),
      .data_in       (data_in),
      .fifo_full     (fifo_full),
      .fifo_empty_0  (fifo_empty_0),
      .fifo_empty_1  (fifo_empty_1),
      .fifo_empty_2  (fifo_empty_2),
      .soft_reset_0  (soft_reset_0),
      .soft_reset_1  (soft_reset_1),
      .soft_reset_2  (soft_reset_2),
      .parity_done   (parity_done),
      .low_pkt_valid (low_pkt_valid),
      .detect_add    (detect_add),
      .lfd_state     (lfd_state),
      .ld_state      (ld_state),
      .laf_state     (laf_state),
      .full_state    (full_state),
      .write_enb_reg (write_enb_reg),
      .rst_int_reg   (rst_int_reg),
      .busy          (busy),
`ifdef ROUTER_PKT_CTRL_WAIT_TIMEOUT_EN
      .pkt_dropped   (pkt_dropped),
`endif
      .state_dbg     (state_dbg)
   );

   // Clock generation
   always #5 clock = ~clock;

   // Advance one clock; inputs change 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      pkt_valid     = 1'b0;
      data_in       = 2'd0;
      fifo_full     = 1'b0;
      fifo_empty_0  = 1'b1;
      fifo_empty_1  = 1'b1;
      fifo_empty_2  = 1'b1;
      soft_reset_0  = 1'b0;
      soft_reset_1  = 1'b0;
      soft_reset_2  = 1'b0;
      parity_done   = 1'b0;
      low_pkt_valid = 1'b0;
   endtask

   // ---------------- reference model ----------------
   typedef enum {M_IDLE, M_HDR, M_PAY, M_STALL, M_RESUME, M_PAR, M_CHK, M_WAIT} mphase_e;

   function automatic logic [7:0] vec_of(input mphase_e p);
      case (p)
         M_IDLE:   return V_DA;
         M_HDR:    return V_LFD;
         M_PAY:    return V_LD;
         M_STALL:  return V_FULL;
         M_RESUME: return V_LAF;
         M_PAR:    return V_LP;
         M_CHK:    return V_CPE;
         default:  return V_WAIT;
      endcase
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      idle_inputs();
      resetn = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      checks++;
      if (dut_vec !== V_DA) begin
         failures++;
         $display("FAIL reset_hold got=%b exp=%b", dut_vec, V_DA);
      end
      checks++;
      if (state_dbg !== 3'd0) begin
         failures++;
         $display("FAIL reset_state got=%0d exp=0", state_dbg);
      end
      resetn = 1'b1;
      data_in = 2'd1; pkt_valid = 1'b1;
      tick();
      tick();
      checks++;
      if (dut_vec !== V_LD) begin
         failures++;
         $display("FAIL reset_pre_ld got=%b exp=%b", dut_vec, V_LD);
      end
      #2 resetn = 1'b0;
      #1;
      checks++;
      if (detect_add !== 1'b1 || write_enb_reg !== 1'b0 || dut_vec !== V_DA) begin
         failures++;
         $display("FAIL reset_async got=%b exp=%b", dut_vec, V_DA);
      end
      checks++;
      if (dut.addr_q !== 2'd0) begin
         failures++;
         $display("FAIL reset_addr got=%0d exp=0", dut.addr_q);
      end
      @(posedge clock);
      #1;
      resetn = 1'b1;
      pkt_valid = 1'b0;
      tick();
      checks++;
      if (dut_vec !== V_DA) begin
         failures++;
         $display("FAIL reset_release got=%b exp=%b", dut_vec, V_DA);
      end
   endtask

   task automatic test_basic_packet();
      logic [7:0] exp_seq [9];
      int rst_cnt;
      exp_seq = '{V_DA, V_LFD, V_LD, V_LD, V_LD, V_LD, V_LP, V_CPE, V_DA};
      rst_cnt = 0;
      idle_inputs();
      for (int c = 0; c < 9; c++) begin
         data_in   = 2'd1;
         pkt_valid = (c < 5);
         checks++;
         if (dut_vec !== exp_seq[c]) begin
            failures++;
            $display("FAIL basic_c%0d got=%b exp=%b", c, dut_vec, exp_seq[c]);
         end
         if (rst_int_reg === 1'b1) rst_cnt++;
         tick();
      end
      checks++;
      if (rst_cnt !== 1) begin
         failures++;
         $display("FAIL basic_rst_int_cycles got=%0d exp=1", rst_cnt);
      end
   endtask

   task automatic test_wait_empty();
      int n_w;
      logic [7:0] exp_v;
      n_w = TIMEOUT_EN ? 5 : 10;
      idle_inputs();
      for (int c = 0; c <= n_w + 5; c++) begin
         data_in      = 2'd2;
         pkt_valid    = (c <= n_w + 1);
         fifo_empty_2 = (c >= n_w);
         if (c == 0)             exp_v = V_DA;
         else if (c <= n_w)      exp_v = V_WAIT;
         else if (c == n_w + 1)  exp_v = V_LFD;
         else if (c == n_w + 2)  exp_v = V_LD;
         else if (c == n_w + 3)  exp_v = V_LP;
         else if (c == n_w + 4)  exp_v = V_CPE;
         else                    exp_v = V_DA;
         checks++;
         if (dut_vec !== exp_v) begin
            failures++;
            $display("FAIL wait_c%0d got=%b exp=%b", c, dut_vec, exp_v);
         end
         tick();
      end
   endtask

   task automatic test_full_stall();
      logic [7:0] exp_v;
      int n_c;
      for (int v = 0; v < 2; v++) begin
         idle_inputs();
         n_c = (v == 0) ? 10 : 8;
         for (int c = 0; c < n_c; c++) begin
            data_in       = 2'd0;
            pkt_valid     = (c <= 5);
            fifo_full     = (c >= 2 && c <= 4);
            low_pkt_valid = (v == 0 && c == 6);
            parity_done   = (v == 1 && c == 6);
            if (c == 0)                   exp_v = V_DA;
            else if (c == 1)              exp_v = V_LFD;
            else if (c == 2)              exp_v = V_LD;
            else if (c <= 5)              exp_v = V_FULL;
            else if (c == 6)              exp_v = V_LAF;
            else if (v == 1)              exp_v = V_DA;
            else if (c == 7)              exp_v = V_LP;
            else if (c == 8)              exp_v = V_CPE;
            else                          exp_v = V_DA;
            checks++;
            if (dut_vec !== exp_v) begin
               failures++;
               $display("FAIL full_v%0d_c%0d got=%b exp=%b", v, c, dut_vec, exp_v);
            end
            tick();
         end
      end
   endtask

   task automatic test_invalid_soft();
      logic [7:0] exp_v;
      idle_inputs();
      for (int c = 0; c < 10; c++) begin
         data_in      = (c < 4) ? 2'd3 : 2'd0;
         pkt_valid    = (c < 8);
         soft_reset_1 = (c == 6);
         soft_reset_0 = (c == 7 || c == 8);
         if (c <= 4)      exp_v = V_DA;
         else if (c == 5) exp_v = V_LFD;
         else if (c <= 7) exp_v = V_LD;
         else             exp_v = V_DA;
         checks++;
         if (dut_vec !== exp_v) begin
            failures++;
            $display("FAIL soft_c%0d got=%b exp=%b", c, dut_vec, exp_v);
         end
         tick();
      end
   endtask

`ifdef ROUTER_PKT_CTRL_WAIT_TIMEOUT_EN
   task automatic test_timeout();
      logic [7:0] exp_v;
      idle_inputs();
      for (int c = 0; c < 11; c++) begin
         data_in      = 2'd1;
         pkt_valid    = (c == 0);
         fifo_empty_1 = 1'b0;
         if (c == 0 || c >= 9) exp_v = V_DA;
         else                  exp_v = V_WAIT;
         checks++;
         if (dut_vec !== exp_v) begin
            failures++;
            $display("FAIL timeout_c%0d got=%b exp=%b", c, dut_vec, exp_v);
         end
         checks++;
         if (pkt_dropped !== (c == 9)) begin
            failures++;
            $display("FAIL timeout_drop_c%0d got=%b exp=%b", c, pkt_dropped, (c == 9));
         end
         tick();
      end
   endtask
`endif

   task automatic test_random();
      mphase_e    m, nxt;
      int         m_addr, m_wait;
      logic       m_drop, nxt_drop;
      logic [2:0] emp, srv;
      idle_inputs();
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      m = M_IDLE; m_addr = 0; m_wait = 0; m_drop = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         pkt_valid     = ($urandom_range(0, 9) < 7);
         data_in       = 2'($urandom_range(0, 3));
         fifo_full     = ($urandom_range(0, 9) < 2);
         fifo_empty_0  = ($urandom_range(0, 9) < 4);
         fifo_empty_1  = ($urandom_range(0, 9) < 4);
         fifo_empty_2  = ($urandom_range(0, 9) < 4);
         soft_reset_0  = ($urandom_range(0, 29) == 0);
         soft_reset_1  = ($urandom_range(0, 29) == 0);
         soft_reset_2  = ($urandom_range(0, 29) == 0);
         parity_done   = ($urandom_range(0, 3) == 0);
         low_pkt_valid = ($urandom_range(0, 3) == 0);
         checks++;
         if (dut_vec !== vec_of(m)) begin
            failures++;
            $display("FAIL rand_c%0d got=%b exp=%b", c, dut_vec, vec_of(m));
         end
`ifdef ROUTER_PKT_CTRL_WAIT_TIMEOUT_EN
         checks++;
         if (pkt_dropped !== m_drop) begin
            failures++;
            $display("FAIL rand_drop_c%0d got=%b exp=%b", c, pkt_dropped, m_drop);
         end
`endif
         // Reference rules applied to this cycle's inputs.
         emp = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
         srv = {soft_reset_2, soft_reset_1, soft_reset_0};
         nxt = m;
         nxt_drop = 1'b0;
         if (m != M_IDLE && srv[m_addr] == 1'b1) begin
            nxt = M_IDLE;
         end else begin
            case (m)
               M_IDLE:   if (pkt_valid && data_in != 2'd3) nxt = emp[data_in] ? M_HDR : M_WAIT;
               M_HDR:    nxt = M_PAY;
               M_PAY:    if (fifo_full) nxt = M_STALL; else if (!pkt_valid) nxt = M_PAR;
               M_STALL:  if (!fifo_full) nxt = M_RESUME;
               M_RESUME: nxt = parity_done ? M_IDLE : (low_pkt_valid ? M_PAR : M_PAY);
               M_PAR:    nxt = M_CHK;
               M_CHK:    nxt = fifo_full ? M_STALL : M_IDLE;
               default: begin
                  if (emp[m_addr] == 1'b1) nxt = M_HDR;
                  else if (TIMEOUT_EN && m_wait == WL - 1) begin
                     nxt = M_IDLE;
                     nxt_drop = 1'b1;
                  end
               end
            endcase
         end
         if (m == M_IDLE && nxt != M_IDLE) m_addr = int'(data_in);
         m_wait = (m == M_WAIT) ? m_wait + 1 : 0;
         m = nxt;
         m_drop = nxt_drop;
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_basic_packet();
      test_wait_empty();
      test_full_stall();
      test_invalid_soft();
`ifdef ROUTER_PKT_CTRL_WAIT_TIMEOUT_EN
      test_timeout();
`endif
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
